// File: rtl/cpu_step_monitor.sv
// cpu_step_monitor
//
// Clock-enable generator and trace snapshot for the single-cycle DE2 CPU.
// A debounced push-button yields exactly one cpu_en pulse per press; the
// run switch instead yields a pulse every RUN_DIV cycles. On every cycle in
// which cpu_en is high, the CPU trace (pc, instruction, register write-back,
// Z flag) is latched into twelve stable display bytes for the LCD.
//
// Ports
//   clk         system clock, all state on the rising edge
//   iRST_N      asynchronous active-low reset
//   step_key    raw push-button, active-low, asynchronous to clk
//   run_sw      raw run switch, high = free run, asynchronous to clk
//   pc          CPU program counter
//   instr       instruction at pc
//   we3/wa3/wd3 CPU register-file write port
//   zero        ALU Z flag
//   cpu_en      CPU clock enable, single-cycle pulses
//   run_active  synchronized run mode
//   d0x0..d0x5  display line 0: pc, instr bytes MSB first, step count low
//   d1x0..d1x5  display line 1: wd3, wa3, we3, zero, write count, step count high

module cpu_step_monitor #(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned RUN_DIV    = 25_000_000
) (
   input  logic        clk,
   input  logic        iRST_N,
   input  logic        step_key,
   input  logic        run_sw,
   input  logic [7:0]  pc,
   input  logic [31:0] instr,
   input  logic        we3,
   input  logic [2:0]  wa3,
   input  logic [7:0]  wd3,
   input  logic        zero,
   output logic        cpu_en,
   output logic        run_active,
   output logic [7:0]  d0x0,
   output logic [7:0]  d0x1,
   output logic [7:0]  d0x2,
   output logic [7:0]  d0x3,
   output logic [7:0]  d0x4,
   output logic [7:0]  d0x5,
   output logic [7:0]  d1x0,
   output logic [7:0]  d1x1,
   output logic [7:0]  d1x2,
   output logic [7:0]  d1x3,
   output logic [7:0]  d1x4,
   output logic [7:0]  d1x5
);

   localparam int unsigned DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   // input synchronizers
   logic             k_s1_q, k_s1_d;
   logic             k_s2_q, k_s2_d;
   logic             run_s1_q, run_s1_d;
   logic             run_s2_q, run_s2_d;

   // debouncer
   logic             deb_q, deb_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   // run-mode divider and enable
   logic [DIV_W-1:0] div_q, div_d;
   logic             cpu_en_q, cpu_en_d;

   // trace snapshot
   logic [7:0]       snap_pc_q, snap_pc_d;
   logic [31:0]      snap_instr_q, snap_instr_d;
   logic [7:0]       snap_wd_q, snap_wd_d;
   logic [2:0]       snap_wa_q, snap_wa_d;
   logic             snap_we_q, snap_we_d;
   logic             snap_z_q, snap_z_d;
   logic [15:0]      step_cnt_q, step_cnt_d;
   logic [7:0]       wr_cnt_q, wr_cnt_d;

   logic             step_pulse;
   logic             run_pulse;

   always_comb begin
      k_s1_d   = step_key;
      k_s2_d   = k_s1_q;
      run_s1_d = run_sw;
      run_s2_d = run_s1_q;
   end

   // Any cycle where the synchronized key agrees with the accepted level
   // clears the count, so a single bounce restarts the whole interval.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (k_s2_q != deb_q) begin
         if (cnt_q == DEB_LAST) begin
            deb_d = k_s2_q;
         end else begin
            cnt_d = cnt_q + DEB_ONE;
         end
      end
   end

   always_comb begin
      div_d = '0;
      if (run_s2_q) begin
         if (div_q != DIV_LAST) begin
            div_d = div_q + DIV_ONE;
         end
      end
   end

   // The press is recognised on the same edge that the debounced level
   // falls, so the pulse lands DEB_CYCLES+2 edges after the key is first
   // sampled low. run_s2 as sampled on that edge selects the pulse source.
   // The cpu_en_q term only matters on a run-to-step switch, where a divider
   // pulse and a press could otherwise land on adjacent cycles.
   always_comb begin
      step_pulse = deb_q && !deb_d && !run_s2_q;
      run_pulse  = run_s2_q && (div_q == DIV_LAST);
      cpu_en_d   = (step_pulse || run_pulse) && !cpu_en_q;
   end

   // Capture on the edge that samples cpu_en high: the CPU executes that
   // step on the same edge, so the bytes show the step just taken.
   always_comb begin
      snap_pc_d    = snap_pc_q;
      snap_instr_d = snap_instr_q;
      snap_wd_d    = snap_wd_q;
      snap_wa_d    = snap_wa_q;
      snap_we_d    = snap_we_q;
      snap_z_d     = snap_z_q;
      step_cnt_d   = step_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      if (cpu_en_q) begin
         snap_pc_d    = pc;
         snap_instr_d = instr;
         snap_wd_d    = wd3;
         snap_wa_d    = wa3;
         snap_we_d    = we3;
         snap_z_d     = zero;
         if (step_cnt_q != 16'hFFFF) begin
            step_cnt_d = step_cnt_q + 16'd1;
         end
         if (we3) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         k_s1_q       <= 1'b1;
         k_s2_q       <= 1'b1;
         run_s1_q     <= 1'b0;
         run_s2_q     <= 1'b0;
         deb_q        <= 1'b1;
         cnt_q        <= '0;
         div_q        <= '0;
         cpu_en_q     <= 1'b0;
         snap_pc_q    <= '0;
         snap_instr_q <= '0;
         snap_wd_q    <= '0;
         snap_wa_q    <= '0;
         snap_we_q    <= 1'b0;
         snap_z_q     <= 1'b0;
         step_cnt_q   <= '0;
         wr_cnt_q     <= '0;
      end else begin
         k_s1_q       <= k_s1_d;
         k_s2_q       <= k_s2_d;
         run_s1_q     <= run_s1_d;
         run_s2_q     <= run_s2_d;
         deb_q        <= deb_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         cpu_en_q     <= cpu_en_d;
         snap_pc_q    <= snap_pc_d;
         snap_instr_q <= snap_instr_d;
         snap_wd_q    <= snap_wd_d;
         snap_wa_q    <= snap_wa_d;
         snap_we_q    <= snap_we_d;
         snap_z_q     <= snap_z_d;
         step_cnt_q   <= step_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign run_active = run_s2_q;

   assign d0x0 = snap_pc_q;
   assign d0x1 = snap_instr_q[31:24];
   assign d0x2 = snap_instr_q[23:16];
   assign d0x3 = snap_instr_q[15:8];
   assign d0x4 = snap_instr_q[7:0];
   assign d0x5 = step_cnt_q[7:0];
   assign d1x0 = snap_wd_q;
   assign d1x1 = {5'b0, snap_wa_q};
   assign d1x2 = {7'b0, snap_we_q};
   assign d1x3 = {7'b0, snap_z_q};
   assign d1x4 = wr_cnt_q;
   assign d1x5 = step_cnt_q[15:8];

endmodule

// File: doc/cpu_step_monitor.md
# cpu_step_monitor

Single-step/free-run clock-enable generator and trace snapshot for the single-cycle CPU on the DE2 board. Upstream of the CPU, it turns a raw push-button or a run switch into one-cycle `cpu_en` pulses. Downstream of the CPU, it captures the CPU trace at each enabled step into twelve stable bytes that drive the LCD debug display (`d0x0`..`d1x5`). It removes the need to clock the CPU directly from a bouncing key.

## Interface
Parameters:
- `DEB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); must be ≥2.
- `RUN_DIV`, default 25_000_000: cycles between `cpu_en` pulses in run mode; must be ≥2.

Ports:
- `clk` in 1: system clock (CLOCK_50); all state on rising edge.
- `iRST_N` in 1: asynchronous, active-low reset.
- `step_key` in 1: raw push-button, active-low, asynchronous to `clk`.
- `run_sw` in 1: raw run-mode switch, high = free run, asynchronous.
- `pc` in 8: CPU program counter.
- `instr` in 32: instruction at `pc`.
- `we3`, `wa3[2:0]`, `wd3[7:0]` in 1/3/8: CPU register-file write port.
- `zero` in 1: ALU Z flag.
- `cpu_en` out 1: CPU clock enable, one-cycle pulses.
- `run_active` out 1: synchronized run mode.
- `d0x0`..`d0x5`, `d1x0`..`d1x5` out 8 each: LCD display bytes.

## Operation
- Synchronizers: `step_key` and `run_sw` each pass through 2 flops (`k_s2`, `run_s2`). Both reset to 1 and 0 respectively. `run_active = run_s2`.
- Debouncer: `deb` resets to 1, `cnt` resets to 0.
  - If `k_s2 == deb`, `cnt <= 0`.
  - Otherwise, if `cnt == DEB_CYCLES-1`, then `deb <= k_s2` and `cnt <= 0`; else `cnt++`.
  - Any single-cycle disagreement restarts the count.
- Step pulse: registered. `cpu_en <= 1` on the edge where `deb` goes 1→0 and `run_s2 == 0`. Release (0→1) never produces a pulse. A held key produces exactly one pulse.
- Run divider: `div` resets to 0 and is held at 0 while `run_s2 == 0`.
  - While `run_s2 == 1`: `div` counts 0..RUN_DIV-1 and wraps.
  - `cpu_en <= 1` on the edge where `div == RUN_DIV-1`.
  - Key presses are ignored in run mode; the debouncer keeps tracking.
- Snapshot: on every edge where `cpu_en == 1`, capture:
  - `d0x0 = pc`, `d0x1 = instr[31:24]`, `d0x2 = instr[23:16]`, `d0x3 = instr[15:8]`, `d0x4 = instr[7:0]`
  - `d1x0 = wd3`, `d1x1 = {5'b0, wa3}`, `d1x2 = {7'b0, we3}`, `d1x3 = {7'b0, zero}`
  - The display therefore shows the instruction executed by that step and its write-back.
- Counters:
  - `step_cnt[15:0]` increments on each capture and saturates at 16'hFFFF. `d0x5 = step_cnt[7:0]`, `d1x5 = step_cnt[15:8]`.
  - `wr_cnt[7:0]` increments on captures with `we3 == 1` and wraps FF→00. `d1x4 = wr_cnt`.
- Reset: all display bytes, counters, `cpu_en` and `div` go to 0 immediately, mid-debounce or mid-interval included.

## Timing
- Step latency: `cpu_en` is high for exactly one cycle, DEB_CYCLES+2 rising edges after the first edge that samples `step_key` low. The key must stay low throughout.
- Run latency: first pulse RUN_DIV+2 edges after `run_sw` rises, accounting for the 2-flop sync. Pulses then follow every RUN_DIV cycles. `run_sw` falling stops pulses within 2 cycles. A pulse already registered in `cpu_en` still completes.
- Display bytes and counters update on the edge that samples `cpu_en = 1`, i.e. visible one cycle after the pulse. They hold stable between pulses.
- `cpu_en` is never high for 2 consecutive cycles, given RUN_DIV ≥ 2.
- At most one capture per pulse. Mode change on the same edge as a debounced press gives no step pulse, because the `run_s2` value sampled at that edge decides.

## Test plan
- Reset: assert `iRST_N = 0` mid-run → all outputs 0 asynchronously, and `cpu_en` stays 0 for 10 cycles after release with inputs idle.
- Bounce (DEB_CYCLES=4): `step_key` toggles 0/1/0/1/0 at 1-cycle intervals, then held low 20 cycles → exactly one `cpu_en` pulse, 6 edges after the final low; release → no pulse.
- Capture: `pc=8'h05`, `instr=32'hDEADBEEF`, `we3=1`, `wa3=3`, `wd3=8'h7A`, `zero=1` at pulse → `d0x0=05`, `d0x1..4=DE AD BE EF`, `d1x0=7A`, `d1x1=03`, `d1x2=01`, `d1x3=01`, `d1x4=01`, `d0x5=01`.
- Run mode (RUN_DIV=4): `run_sw=1` for 40 cycles → pulses every 4 cycles, first at edge 6; a key press meanwhile adds no extra pulse; `run_sw=0` → pulses stop.
- Counters (RUN_DIV=2, `we3=1`): 65,540 pulses → `d0x5/d1x5` hold FF/FF; `d1x4` = (65540 mod 256) = 04.
- Reset mid-debounce: `iRST_N` pulsed while `cnt = 2` → no `cpu_en`; key must be re-held DEB_CYCLES+2 edges to step.
